bcd_multi_accumulator: RTL

//   Parametrised N-channel BCD digit accumulator: converts a stream of BCD digits,

---
 rtl/bcd_multi_accumulator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bcd_multi_accumulator.sv
// N-channel BCD digit accumulator: a steered digit stream is folded into binary
// (acc*10 + digit) per channel, with sign, overflow/bad-digit flags and a result handshake.

module bcd_acc_chan #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat,
  input  logic [3:0]       digit,
  input  logic             last,
  input  logic             neg,
  input  logic             clr,
  input  logic             take,
  output logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] num_digits,
  output logic             done,
  output logic             overflow,
  output logic             bad_digit
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [WIDTH+3:0] TEN     = (WIDTH+4)'(10);
  localparam logic [WIDTH-1:0] VAL_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [WIDTH+3:0] prod;
  logic [WIDTH-1:0] mag, value_nxt;
  logic             digit_ok, mul_ovf, neg_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) state_nxt = IDLE;
    else begin
      case (state)
        IDLE, ACCUM: if (beat) state_nxt = last ? DONE : ACCUM;
        DONE:        if (take) state_nxt = IDLE;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  always_comb done = (state == DONE);

  // Once saturated the value is all-ones, so every further digit overflows again.
  always_comb begin
    digit_ok  = (digit <= 4'd9);
    prod      = {4'b0, value} * TEN + {{WIDTH{1'b0}}, digit};
    mul_ovf   = digit_ok && (prod[WIDTH+3:WIDTH] != 4'b0);
    mag       = !digit_ok ? value : (mul_ovf ? {WIDTH{1'b1}} : prod[WIDTH-1:0]);
    neg_ovf   = last && neg && (mag > VAL_MIN);
    value_nxt = mag;
    if (last && neg) value_nxt = neg_ovf ? VAL_MIN : -mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value      <= '0;
      num_digits <= '0;
      overflow   <= 1'b0;
      bad_digit  <= 1'b0;
    end else if (clr || (done && take)) begin
      value      <= '0;
      num_digits <= '0;
      overflow   <= 1'b0;
      bad_digit  <= 1'b0;
    end else if (beat) begin
      value     <= value_nxt;
      overflow  <= overflow | mul_ovf | neg_ovf;
      bad_digit <= bad_digit | !digit_ok;
      if (digit_ok && (num_digits != {CNT_W{1'b1}})) num_digits <= num_digits + 1'b1;
    end
  end
endmodule

module bcd_multi_accumulator #(
  parameter int NUM_CHANNELS = 3,
  parameter int WIDTH        = 64,
  parameter int CNT_W        = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_digit,
  input  logic [NUM_CHANNELS-1:0] in_chan_sel,
  input  logic                    in_last,
  input  logic                    in_neg,
  input  logic [NUM_CHANNELS-1:0] clear,
  output logic [WIDTH-1:0]        out_value [NUM_CHANNELS],
  output logic [CNT_W-1:0]        out_num_digits [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] out_valid,
  input  logic [NUM_CHANNELS-1:0] out_ready,
  output logic [NUM_CHANNELS-1:0] out_overflow,
  output logic [NUM_CHANNELS-1:0] out_bad_digit
);
  logic [NUM_CHANNELS-1:0] done;

  // A channel holding a result or being cleared refuses beats; others stay open.
  assign in_ready  = !rst && $onehot(in_chan_sel) &&
                     ((in_chan_sel & (done | clear)) == '0);
  assign out_valid = done;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    bcd_acc_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan (
      .clk        (clk),
      .rst        (rst),
      .beat       (in_valid && in_ready && in_chan_sel[g]),
      .digit      (in_digit),
      .last       (in_last),
      .neg        (in_neg),
      .clr        (clear[g]),
      .take       (out_ready[g]),
      .value      (out_value[g]),
      .num_digits (out_num_digits[g]),
      .done       (done[g]),
      .overflow   (out_overflow[g]),
      .bad_digit  (out_bad_digit[g])
    );
  end
endmodule
